// File: rtl/proc_ctrl_datapath.sv
// proc_ctrl_datapath
//   Multi-cycle 10-bit processor core: instruction register, general registers
//   R0..R3, accumulator A, result register G, add/sub ALU, shared bus mux and a
//   four-state timestep FSM (T0..T3).
//
//   Instruction word IR[9:0]:
//     [9:8] opcode  00 mv, 01 mvi, 10 add, 11 sub
//     [7:6] X       destination / first operand
//     [5:4] Y       source
//     [3:0] ignored
//
//   Handshake: RUN is a request level qualified only in T0. When the FSM is in
//   T0 and a fetch is requested, IR captures DIN on that edge and the
//   instruction runs to completion. RUN is ignored in T1..T3, so a request can
//   never interrupt an instruction. DONE marks the last timestep of every
//   instruction, and is high for exactly one cycle.
//
//   Optional build macro: RUN_EDGE_EN
//     undefined : level-sensitive RUN (holding RUN high runs back-to-back)
//     defined   : RUN is registered once and a fetch needs a 0->1 transition,
//                 so holding RUN high runs exactly one instruction.
//
//   Debug visibility: the FSM state is exported directly as TSTEP.

module proc_ctrl_datapath #(
  parameter int REG_SEL = 1
) (
  input  logic       CLKb,
  input  logic       CLRb,
  input  logic       RUN,
  input  logic [9:0] DIN,
  output logic [9:0] BUS,
  output logic [9:0] REG,
  output logic [1:0] TSTEP,
  output logic       DONE
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [1:0] REG_IDX = 2'(REG_SEL);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  tstep_t     state;
  tstep_t     state_nxt;

  logic [9:0] ir;
  logic [9:0] r [4];
  logic [9:0] a;
  logic [9:0] g;

  // Decoded instruction fields
  logic [1:0] op;
  logic [1:0] x;
  logic [1:0] y;

  // Control strobes produced by the output decode
  logic       fetch;
  logic       ir_wr;
  logic       r_wr;
  logic       a_wr;
  logic       g_wr;
  logic       done_c;
  logic [9:0] bus_c;
  logic [9:0] alu_res;

  // The low nibble of IR carries no meaning; fold it so it is visibly consumed.
  logic       unused_ir_bits;

  assign op             = ir[9:8];
  assign x              = ir[7:6];
  assign y              = ir[5:4];
  assign unused_ir_bits = ^ir[3:0];

  // ---------------------------------------------------------------------------
  // Fetch qualification
  // ---------------------------------------------------------------------------
`ifdef RUN_EDGE_EN
  logic run_q;

  // Remember the previous RUN sample so T0 can detect a rising edge.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      run_q <= 1'b0;
    end else begin
      run_q <= RUN;
    end
  end

  // Current RUN high and previous sample low: one fetch per key press.
  assign fetch = RUN & ~run_q;
`else
  // Level-sensitive: any cycle in T0 with RUN high starts an instruction.
  assign fetch = RUN;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // Timestep register; reset aborts any instruction and returns to T0.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      state <= T0;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // mv/mvi finish in T1; add/sub (opcode MSB set) continue through T2 and T3.
  always_comb begin
    state_nxt = T0;
    case (state)
      T0:      state_nxt = fetch ? T1 : T0;
      T1:      state_nxt = op[1] ? T2 : T0;
      T2:      state_nxt = T3;
      T3:      state_nxt = T0;
      default: state_nxt = T0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (bus select, write strobes, DONE)
  // ---------------------------------------------------------------------------
  // The bus defaults to DIN, which is what T0 (and reset) must show.
  always_comb begin
    bus_c  = DIN;
    ir_wr  = 1'b0;
    r_wr   = 1'b0;
    a_wr   = 1'b0;
    g_wr   = 1'b0;
    done_c = 1'b0;
    case (state)
      T0: begin
        bus_c = DIN;
        ir_wr = fetch;
      end
      T1: begin
        case (op)
          OP_MV: begin
            bus_c  = r[y];
            r_wr   = 1'b1;
            done_c = 1'b1;
          end
          OP_MVI: begin
            bus_c  = DIN;
            r_wr   = 1'b1;
            done_c = 1'b1;
          end
          default: begin
            bus_c = r[x];
            a_wr  = 1'b1;
          end
        endcase
      end
      T2: begin
        bus_c = r[y];
        g_wr  = 1'b1;
      end
      T3: begin
        bus_c  = g;
        r_wr   = 1'b1;
        done_c = 1'b1;
      end
      default: begin
        bus_c = DIN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU: modulo-1024 add or subtract of A and the bus, no carry out
  // ---------------------------------------------------------------------------
  // Subtract only for the sub opcode; add otherwise (only consumed in T2).
  always_comb begin
    alu_res = a + bus_c;
    if (op == OP_SUB) begin
      alu_res = a - bus_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // IR captures the instruction word on the fetch edge and holds otherwise.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      ir <= '0;
    end else if (ir_wr) begin
      ir <= DIN;
    end
  end

  // General registers: every write to R[X] takes its data from the bus.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      for (int i = 0; i < 4; i++) begin
        r[i] <= '0;
      end
    end else if (r_wr) begin
      r[x] <= bus_c;
    end
  end

  // Accumulator A latches the first operand in T1 of add/sub.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      a <= '0;
    end else if (a_wr) begin
      a <= bus_c;
    end
  end

  // Result register G latches the ALU output in T2 of add/sub.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      g <= '0;
    end else if (g_wr) begin
      g <= alu_res;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (combinational from state and registers)
  // ---------------------------------------------------------------------------
  assign BUS   = bus_c;
  assign REG   = r[REG_IDX];
  assign TSTEP = state;
  assign DONE  = done_c;

endmodule

// File: tb/tb_proc_ctrl_datapath.sv
// tb_proc_ctrl_datapath
//   Bench for proc_ctrl_datapath (REG_SEL = 1). A register-file model computes
//   the expected {DONE, TSTEP, BUS} for every cycle as stimulus is driven and
//   pushes it to exp_q; a negedge monitor pops and compares. REG is compared
//   against the model after every instruction. Registers other than R1 are
//   observed non-destructively with "mv Ry,Ry", which puts R[Y] on the bus.
//   Build with +define+RUN_EDGE_EN to check the edge-triggered RUN variant.

module tb_proc_ctrl_datapath;

  localparam int REG_SEL = 1;

  logic       CLKb;
  logic       CLRb;
  logic       RUN;
  logic [9:0] DIN;
  logic [9:0] BUS;
  logic [9:0] REG;
  logic [1:0] TSTEP;
  logic       DONE;

  int         n_tests;
  int         n_fail;

  logic [12:0] exp_q[$];
  logic [9:0]  m_r [4];

  proc_ctrl_datapath #(.REG_SEL(REG_SEL)) dut (
    .CLKb  (CLKb),
    .CLRb  (CLRb),
    .RUN   (RUN),
    .DIN   (DIN),
    .BUS   (BUS),
    .REG   (REG),
    .TSTEP (TSTEP),
    .DONE  (DONE)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    CLKb = 1'b0;
    forever #5 CLKb = ~CLKb;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pack(input logic done, input logic [1:0] ts,
                                       input logic [9:0] bus);
    return {done, ts, bus};
  endfunction

  // Scoreboard monitor: one expected {DONE,TSTEP,BUS} per driven cycle.
  always @(negedge CLKb) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      check_eq($sformatf("cycle t=%0t", $time), {3'b000, DONE, TSTEP, BUS},
               {3'b000, e});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge CLKb);
    #1;
  endtask

  task automatic drive_cycle(input logic run, input logic [9:0] din,
                             input logic [12:0] e);
    RUN = run;
    DIN = din;
    exp_q.push_back(e);
    next_cycle();
  endtask

  task automatic idle(input logic run, input logic [9:0] din);
    drive_cycle(run, din, pack(1'b0, 2'd0, din));
    check_eq("idle_reg", {6'd0, REG}, {6'd0, m_r[REG_SEL]});
  endtask

  // mode 0: RUN only in T0; 1: RUN held every cycle; 2: RUN again only in T2
  task automatic issue(input logic [9:0] instr, input logic [9:0] imm,
                       input int mode);
    logic [1:0] op;
    logic [1:0] x;
    logic [1:0] y;
    logic [9:0] res;
    op = instr[9:8];
    x  = instr[7:6];
    y  = instr[5:4];
    drive_cycle(1'b1, instr, pack(1'b0, 2'd0, instr));
    case (op)
      2'b00: begin
        drive_cycle(mode == 1, imm, pack(1'b1, 2'd1, m_r[y]));
        m_r[x] = m_r[y];
      end
      2'b01: begin
        drive_cycle(mode == 1, imm, pack(1'b1, 2'd1, imm));
        m_r[x] = imm;
      end
      default: begin
        res = (op == 2'b10) ? m_r[x] + m_r[y] : m_r[x] - m_r[y];
        drive_cycle(mode == 1, imm, pack(1'b0, 2'd1, m_r[x]));
        drive_cycle(mode != 0, imm, pack(1'b0, 2'd2, m_r[y]));
        drive_cycle(mode == 1, imm, pack(1'b1, 2'd3, res));
        m_r[x] = res;
      end
    endcase
    check_eq("reg_out", {6'd0, REG}, {6'd0, m_r[REG_SEL]});
  endtask

  task automatic peek(input logic [1:0] ry);
    logic [9:0] instr;
    instr = {2'b00, ry, ry, 4'h0};
    issue(instr, 10'($urandom_range(0, 1023)), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4; i++) m_r[i] = '0;

    // Reset state
    CLRb = 1'b0;
    RUN  = 1'b0;
    DIN  = 10'h2AA;
    #3;
    check_eq("rst_tstep", {14'd0, TSTEP}, 16'd0);
    check_eq("rst_reg",   {6'd0, REG},    16'd0);
    check_eq("rst_done",  {15'd0, DONE},  16'd0);
    check_eq("rst_bus",   {6'd0, BUS},    16'h2AA);
    RUN = 1'b1;
    repeat (2) next_cycle();
    check_eq("rst_hold_tstep", {14'd0, TSTEP}, 16'd0);
    RUN = 1'b0;
    @(negedge CLKb);
    #1 CLRb = 1'b1;
    next_cycle();

    // Idle: bus follows DIN, FSM stays in T0
    for (int i = 0; i < 4; i++) idle(1'b0, (i % 2 == 0) ? 10'h2AA : 10'h155);

    // mvi R0,0x155 then mv R1,R0
    issue(10'h100, 10'h155, 0);
    issue(10'h040, 10'h0F0, 0);
    check_eq("mv_r1", {6'd0, REG}, 16'h155);

    // add wrap: R0=0x3FF, R1=0x001, add R0,R1
    issue(10'h100, 10'h3FF, 0);
    issue(10'h140, 10'h001, 0);
    issue(10'h210, 10'h2AA, 0);
    peek(2'd0);

    // sub underflow and X=Y
    issue(10'h180, 10'h005, 0);
    issue(10'h1C0, 10'h007, 0);
    issue(10'h3B0, 10'h111, 0);
    peek(2'd2);
    issue(10'h3F0, 10'h222, 0);
    peek(2'd3);
    issue(10'h250, 10'h333, 0);   // add R1,R1 doubles
    issue(10'h000, 10'h333, 0);   // mv R0,R0 unchanged
    peek(2'd0);

    // RUN pulsed during T2 of an add: no extra fetch afterwards
    issue(10'h260, 10'h0AA, 2);
    idle(1'b0, 10'h155);
    idle(1'b0, 10'h2AA);

    // RUN held high over mvi-length instructions
`ifdef RUN_EDGE_EN
    issue(10'h140, 10'h011, 1);
    for (int i = 0; i < 4; i++) idle(1'b1, 10'h180);
    idle(1'b0, 10'h180);
`else
    issue(10'h140, 10'h011, 1);
    issue(10'h180, 10'h022, 1);
    issue(10'h1C0, 10'h033, 1);
    idle(1'b0, 10'h155);
`endif
    for (int i = 0; i < 4; i++) peek(2'(i));

    // Random instruction mix
    for (int i = 0; i < 24; i++) begin
      issue(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 0);
      if ($urandom_range(0, 3) == 0) idle(1'b0, 10'($urandom_range(0, 1023)));
    end
    for (int i = 0; i < 4; i++) peek(2'(i));

    // Reset in T2 of an add aborts it and clears everything
    issue(10'h140, 10'h2A5, 0);
    drive_cycle(1'b1, 10'h210, pack(1'b0, 2'd0, 10'h210));
    drive_cycle(1'b0, 10'h3C3, pack(1'b0, 2'd1, m_r[0]));
    check_eq("pre_rst_tstep", {14'd0, TSTEP}, 16'd2);
    #2 CLRb = 1'b0;
    #1;
    check_eq("mid_rst_tstep", {14'd0, TSTEP}, 16'd0);
    check_eq("mid_rst_reg",   {6'd0, REG},    16'd0);
    check_eq("mid_rst_done",  {15'd0, DONE},  16'd0);
    check_eq("mid_rst_bus",   {6'd0, BUS},    16'h3C3);
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    @(negedge CLKb);
    #1 CLRb = 1'b1;
    next_cycle();
    check_eq("post_rst_tstep", {14'd0, TSTEP}, 16'd0);
    for (int i = 0; i < 4; i++) peek(2'(i));

    idle(1'b0, 10'h000);
    check_eq("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
